// File: rtl/axi_io_pmp_err_slv_pkg.sv
// Shared types for the IO-PMP error slave: response codes, counter type, default AXI structs.
package axi_io_pmp_err_slv_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_trans_resp_t;

    typedef logic [31:0] axi_err_slv_cnt_t;

    localparam logic [63:0] ErrSlvDefaultData = 64'hBADCAB1E;
    // ATOP_R_RESP: atomics with this bit set also expect an R burst
    localparam int unsigned AtopRRespBit = 5;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [5:0]  atop;
        logic [0:0]  user;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [0:0]  user;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [0:0]  user;
    } axi_w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        axi_r_chan_t r;
    } axi_resp_t;

    function automatic axi_err_slv_cnt_t sat_inc(input axi_err_slv_cnt_t c);
        return (c == '1) ? c : c + axi_err_slv_cnt_t'(1);
    endfunction

endpackage

// File: rtl/axi_err_id_fifo.sv
// Generic circular FIFO holding per-transaction bookkeeping; head is combinational, no bypass.
// Push and pop in one cycle both take effect; full/empty depend only on stored occupancy.
module axi_err_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  dtype data_i,
    input  logic pop_i,
    output dtype head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    typedef logic [PtrW-1:0] ptr_t;
    localparam ptr_t LastPtr = ptr_t'(DEPTH - 1);

    dtype            mem_q [DEPTH];
    ptr_t            wr_q, rd_q;
    logic [CntW-1:0] cnt_q;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= (wr_q == LastPtr) ? '0 : wr_q + ptr_t'(1);
            end
            if (pop_i) rd_q <= (rd_q == LastPtr) ? '0 : rd_q + ptr_t'(1);
            if (push_i && !pop_i)      cnt_q <= cnt_q + CntW'(1);
            else if (pop_i && !push_i) cnt_q <= cnt_q - CntW'(1);
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/axi_io_pmp_err_slv.sv
// AXI4+ATOP error slave: drains W, returns one error B per write and len+1 error R beats per read.
// B one cycle after last W; R streams 1 beat/cycle; AW-with-ATOP_R_RESP takes the AR FIFO push port first.
module axi_io_pmp_err_slv
    import axi_io_pmp_err_slv_pkg::*;
#(
    parameter int unsigned     AddrWidth = 64,
    parameter int unsigned     DataWidth = 64,
    parameter int unsigned     IdWidth   = 4,
    parameter int unsigned     UserWidth = 1,
    parameter int unsigned     MaxTxns   = 4,
    parameter axi_trans_resp_t RespCode  = RESP_DECERR,
    parameter logic [63:0]     RespData  = ErrSlvDefaultData,
    parameter type             req_t     = axi_req_t,
    parameter type             resp_t    = axi_resp_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  req_t        slv_req_i,
    output resp_t       slv_resp_o,
    output logic [31:0] wr_err_cnt_o,
    output logic [31:0] rd_err_cnt_o,
    output logic        busy_o
);
    typedef logic [IdWidth-1:0] id_t;
    typedef struct packed {
        id_t        id;
        logic [7:0] len;
    } ar_ent_t;

    logic             accept_en_q;
    logic             aw_full, aw_empty, ar_full, ar_empty;
    id_t              aw_head;
    ar_ent_t          ar_head, ar_push_dat;
    logic             aw_atop, aw_ready, ar_ready, w_ready, r_last;
    logic             aw_hs, ar_hs, w_hs, b_hs, r_hs, ar_push, ar_pop;
    logic             b_valid_q, b_valid_d;
    logic [7:0]       beat_q, beat_d;
    axi_err_slv_cnt_t wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic             unused_req;

    assign unused_req = ^{slv_req_i, AddrWidth[0], UserWidth[0]};

    assign aw_atop  = slv_req_i.aw.atop[AtopRRespBit];
    // Readies stay low for the first cycle after reset release
    assign aw_ready = accept_en_q && !aw_full && !(aw_atop && ar_full);
    assign ar_ready = accept_en_q && !ar_full && !(slv_req_i.aw_valid && aw_atop);
    assign w_ready  = !aw_empty && !b_valid_q;
    assign r_last   = (beat_q == ar_head.len);

    assign aw_hs   = slv_req_i.aw_valid && aw_ready;
    assign ar_hs   = slv_req_i.ar_valid && ar_ready;
    assign w_hs    = slv_req_i.w_valid && w_ready;
    assign b_hs    = b_valid_q && slv_req_i.b_ready;
    assign r_hs    = !ar_empty && slv_req_i.r_ready;
    assign ar_push = ar_hs || (aw_hs && aw_atop);
    assign ar_pop  = r_hs && r_last;

    always_comb begin
        ar_push_dat = '{id: slv_req_i.ar.id, len: slv_req_i.ar.len};
        if (aw_hs && aw_atop) ar_push_dat = '{id: slv_req_i.aw.id, len: slv_req_i.aw.len};
    end

    axi_err_id_fifo #(.DEPTH(MaxTxns), .dtype(id_t)) i_aw_fifo (
        .clk_i, .rst_i, .push_i(aw_hs), .data_i(slv_req_i.aw.id), .pop_i(b_hs),
        .head_o(aw_head), .full_o(aw_full), .empty_o(aw_empty)
    );

    axi_err_id_fifo #(.DEPTH(MaxTxns), .dtype(ar_ent_t)) i_ar_fifo (
        .clk_i, .rst_i, .push_i(ar_push), .data_i(ar_push_dat), .pop_i(ar_pop),
        .head_o(ar_head), .full_o(ar_full), .empty_o(ar_empty)
    );

    assign b_valid_d = b_hs ? 1'b0 : ((w_hs && slv_req_i.w.last) ? 1'b1 : b_valid_q);
    assign beat_d    = r_hs ? (r_last ? 8'd0 : beat_q + 8'd1) : beat_q;
    assign wr_cnt_d  = b_hs ? sat_inc(wr_cnt_q) : wr_cnt_q;
    assign rd_cnt_d  = ar_pop ? sat_inc(rd_cnt_q) : rd_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            accept_en_q <= 1'b0;
            b_valid_q   <= 1'b0;
            beat_q      <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            accept_en_q <= 1'b1;
            b_valid_q   <= b_valid_d;
            beat_q      <= beat_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_ready;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.w_ready  = w_ready;
        slv_resp_o.b_valid  = b_valid_q;
        slv_resp_o.b.id     = aw_head;
        slv_resp_o.b.resp   = RespCode;
        slv_resp_o.r_valid  = !ar_empty;
        slv_resp_o.r.id     = ar_head.id;
        slv_resp_o.r.data   = DataWidth'(RespData);
        slv_resp_o.r.resp   = RespCode;
        slv_resp_o.r.last   = r_last;
    end

    assign wr_err_cnt_o = wr_cnt_q;
    assign rd_err_cnt_o = rd_cnt_q;
    assign busy_o       = !aw_empty || !ar_empty || b_valid_q;

    a_ar_port_single: assert property (@(posedge clk_i) disable iff (rst_i) !(ar_hs && aw_hs && aw_atop));

endmodule

// File: tb/tb_axi_io_pmp_err_slv.sv
// Directed and randomized checks of the error slave against a transaction-level queue model.
module tb_axi_io_pmp_err_slv;
    import axi_io_pmp_err_slv_pkg::*;

    localparam int IW = 6;
    localparam logic [63:0] EXP_DATA = 64'h0000_0000_BADC_AB1E;
    localparam logic [1:0]  EXP_RESP = 2'b11;

    typedef struct packed {
        logic [IW-1:0] id; logic [63:0] addr; logic [7:0] len; logic [2:0] size;
        logic [1:0] burst; logic [5:0] atop; logic [0:0] user;
    } aw_t;
    typedef struct packed {
        logic [IW-1:0] id; logic [63:0] addr; logic [7:0] len; logic [2:0] size;
        logic [1:0] burst; logic [0:0] user;
    } ar_t;
    typedef struct packed { logic [63:0] data; logic [7:0] strb; logic last; logic [0:0] user; } w_t;
    typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; logic [0:0] user; } b_t;
    typedef struct packed {
        logic [IW-1:0] id; logic [63:0] data; logic [1:0] resp; logic last; logic [0:0] user;
    } r_t;
    typedef struct packed {
        aw_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
        ar_t ar; logic ar_valid; logic r_ready;
    } req_t;
    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_t b; logic r_valid; r_t r;
    } resp_t;

    typedef struct { int id; int len; bit atop; } awstim_t;
    typedef struct { int id; int len; } burst_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    req_t        req;
    resp_t       resp;
    logic [31:0] wr_cnt, rd_cnt;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    axi_io_pmp_err_slv #(
        .AddrWidth(64), .DataWidth(64), .IdWidth(IW), .UserWidth(1), .MaxTxns(2),
        .RespCode(RESP_DECERR), .RespData(64'hBADCAB1E), .req_t(req_t), .resp_t(resp_t)
    ) dut (
        .clk_i(clk), .rst_i(rst), .slv_req_i(req), .slv_resp_o(resp),
        .wr_err_cnt_o(wr_cnt), .rd_err_cnt_o(rd_cnt), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic send_aw(input int id, input int len, input logic [5:0] atop);
        int n = 0;
        req.aw = '0; req.aw.id = IW'(id); req.aw.len = 8'(len); req.aw.atop = atop;
        req.aw_valid = 1'b1;
        @(negedge clk);
        while (!resp.aw_ready && n < 100) begin @(negedge clk); n++; end
        chk("aw_accept", resp.aw_ready, 1);
        tick;
        req.aw_valid = 1'b0;
    endtask

    task automatic send_ar(input int id, input int len);
        int n = 0;
        req.ar = '0; req.ar.id = IW'(id); req.ar.len = 8'(len);
        req.ar_valid = 1'b1;
        @(negedge clk);
        while (!resp.ar_ready && n < 100) begin @(negedge clk); n++; end
        chk("ar_accept", resp.ar_ready, 1);
        tick;
        req.ar_valid = 1'b0;
    endtask

    initial begin
        awstim_t aw_stim[$];
        burst_t  ar_stim[$];
        burst_t  exp_r[$];
        bit      w_stim[$];
        int      aw_acc[$];
        int      exp_b[$];
        logic [IW-1:0] ids[$];
        logic          lasts[$];
        int n_wr, n_rd, seen, acc_at, rbeat, cyc, nb;
        bit drained, aw_hs, ar_hs, w_hs, b_hs, r_hs, got_last, acc_now;

        // reset state
        req = '0;
        repeat (2) @(negedge clk);
        chk("rst_aw_ready", resp.aw_ready, 0);
        chk("rst_ar_ready", resp.ar_ready, 0);
        chk("rst_w_ready", resp.w_ready, 0);
        chk("rst_b_valid", resp.b_valid, 0);
        chk("rst_r_valid", resp.r_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_rd_cnt", rd_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_aw_ready", resp.aw_ready, 1);
        tick;

        // 1: single write burst
        send_aw(3, 3, 6'b0);
        for (int i = 0; i < 4; i++) begin
            req.w_valid = 1'b1; req.w.last = (i == 3); req.w.data = {$urandom, $urandom};
            @(negedge clk);
            chk("t1_w_ready", resp.w_ready, 1);
            chk("t1_b_early", resp.b_valid, 0);
            tick;
        end
        req.w_valid = 1'b0; req.w.last = 1'b0;
        @(negedge clk);
        chk("t1_b_valid", resp.b_valid, 1);
        chk("t1_b_id", resp.b.id, 3);
        chk("t1_b_resp", resp.b.resp, EXP_RESP);
        chk("t1_b_user", resp.b.user, 0);
        tick;
        @(negedge clk);
        chk("t1_b_hold", resp.b_valid, 1);
        tick;
        req.b_ready = 1'b1;
        tick;
        req.b_ready = 1'b0;
        @(negedge clk);
        chk("t1_b_clear", resp.b_valid, 0);
        chk("t1_wr_cnt", wr_cnt, 1);
        chk("t1_busy", busy, 0);

        // 2: 8-beat read
        tick;
        req.r_ready = 1'b1;
        send_ar(5, 7);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            chk("t2_r_valid", resp.r_valid, 1);
            chk("t2_r_id", resp.r.id, 5);
            chk("t2_r_data", resp.r.data, EXP_DATA);
            chk("t2_r_resp", resp.r.resp, EXP_RESP);
            chk("t2_r_last", resp.r.last, (b == 7));
        end
        @(negedge clk);
        chk("t2_r_done", resp.r_valid, 0);
        chk("t2_rd_cnt", rd_cnt, 1);

        // 3: AR FIFO fills at 2 entries
        tick;
        req.r_ready = 1'b0;
        send_ar(10, 1);
        send_ar(11, 1);
        req.ar = '0; req.ar.id = IW'(12); req.ar.len = 8'd1; req.ar_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_ar_full", resp.ar_ready, 0);
        end
        tick;
        req.r_ready = 1'b1;
        seen = 0; acc_at = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            acc_now = req.ar_valid && resp.ar_ready;
            if (acc_now) acc_at = seen;
            if (resp.r_valid && req.r_ready) begin
                ids.push_back(resp.r.id); lasts.push_back(resp.r.last); seen++;
            end
            tick;
            if (acc_now) req.ar_valid = 1'b0;
        end
        chk("t3_accept_after_burst", acc_at, 2);
        chk("t3_beats", seen, 6);
        for (int i = 0; i < 6; i++) if (i < ids.size()) begin
            chk("t3_r_id", ids[i], 10 + i / 2);
            chk("t3_r_last", lasts[i], i % 2);
        end
        chk("t3_rd_cnt", rd_cnt, 4);

        // 4: atomic write with R response, concurrent AR yields one cycle
        req.aw = '0; req.aw.id = IW'(1); req.aw.len = 8'd0; req.aw.atop = 6'b100000; req.aw_valid = 1'b1;
        req.ar = '0; req.ar.id = IW'(7); req.ar.len = 8'd0; req.ar_valid = 1'b1;
        req.w_valid = 1'b1; req.w.last = 1'b1; req.b_ready = 1'b1; req.r_ready = 1'b1;
        @(negedge clk);
        chk("t4_aw_ready", resp.aw_ready, 1);
        chk("t4_ar_yield", resp.ar_ready, 0);
        chk("t4_w_wait", resp.w_ready, 0);
        tick;
        req.aw_valid = 1'b0;
        @(negedge clk);
        chk("t4_ar_ready", resp.ar_ready, 1);
        chk("t4_w_ready", resp.w_ready, 1);
        chk("t4_r0_valid", resp.r_valid, 1);
        chk("t4_r0_id", resp.r.id, 1);
        chk("t4_r0_last", resp.r.last, 1);
        tick;
        req.ar_valid = 1'b0; req.w_valid = 1'b0;
        @(negedge clk);
        chk("t4_b_valid", resp.b_valid, 1);
        chk("t4_b_id", resp.b.id, 1);
        chk("t4_r1_valid", resp.r_valid, 1);
        chk("t4_r1_id", resp.r.id, 7);
        chk("t4_r1_last", resp.r.last, 1);
        tick;
        @(negedge clk);
        chk("t4_b_done", resp.b_valid, 0);
        chk("t4_r_done", resp.r_valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_wr_cnt", wr_cnt, 2);
        chk("t4_rd_cnt", rd_cnt, 6);

        // 5: randomized mixed traffic with backpressure
        req = '0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick;
        chk("t5_cnt_cleared", wr_cnt, 0);
        n_wr = 0; n_rd = 0;
        for (int n = 0; n < 1000; n++) begin
            int kind, id, len;
            kind = $urandom_range(0, 2); id = $urandom_range(0, 63); len = $urandom_range(0, 7);
            if (kind < 2) begin
                aw_stim.push_back('{id: id, len: len, atop: (kind == 1)});
                for (int b = 0; b <= len; b++) w_stim.push_back(b == len);
                n_wr++;
                if (kind == 1) n_rd++;
            end else begin
                ar_stim.push_back('{id: id, len: len});
                n_rd++;
            end
        end
        rbeat = 0; cyc = 0; drained = 0;
        while (cyc < 80000 && !drained) begin
            if (!req.aw_valid && aw_stim.size() > 0 && $urandom_range(0, 1) == 1) begin
                req.aw = '0; req.aw.id = IW'(aw_stim[0].id); req.aw.len = 8'(aw_stim[0].len);
                req.aw.atop = aw_stim[0].atop ? 6'b100000 : 6'b000000; req.aw_valid = 1'b1;
            end
            if (!req.ar_valid && ar_stim.size() > 0 && $urandom_range(0, 1) == 1) begin
                req.ar = '0; req.ar.id = IW'(ar_stim[0].id); req.ar.len = 8'(ar_stim[0].len);
                req.ar_valid = 1'b1;
            end
            if (!req.w_valid && w_stim.size() > 0 && $urandom_range(0, 2) != 0) begin
                req.w.last = w_stim[0]; req.w.data = {$urandom, $urandom}; req.w_valid = 1'b1;
            end
            req.b_ready = ($urandom_range(0, 1) == 1);
            req.r_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            aw_hs = req.aw_valid && resp.aw_ready;
            ar_hs = req.ar_valid && resp.ar_ready;
            w_hs  = req.w_valid && resp.w_ready;
            b_hs  = req.b_ready && resp.b_valid;
            r_hs  = req.r_ready && resp.r_valid;
            if (req.ar_valid && req.aw_valid && req.aw.atop[5]) chk("t5_ar_yield", resp.ar_ready, 0);
            if (aw_hs) begin
                aw_acc.push_back(aw_stim[0].id);
                if (aw_stim[0].atop) exp_r.push_back('{id: aw_stim[0].id, len: aw_stim[0].len});
                void'(aw_stim.pop_front());
            end
            if (ar_hs) begin
                exp_r.push_back(ar_stim[0]);
                void'(ar_stim.pop_front());
            end
            if (w_hs) begin
                chk("t5_w_after_aw", aw_acc.size() > 0, 1);
                if (w_stim[0] && aw_acc.size() > 0) exp_b.push_back(aw_acc.pop_front());
                void'(w_stim.pop_front());
            end
            if (b_hs) begin
                chk("t5_b_pending", exp_b.size() > 0, 1);
                if (exp_b.size() > 0) begin
                    chk("t5_b_id", resp.b.id, exp_b[0]);
                    chk("t5_b_resp", resp.b.resp, EXP_RESP);
                    void'(exp_b.pop_front());
                end
            end
            if (r_hs) begin
                chk("t5_r_pending", exp_r.size() > 0, 1);
                if (exp_r.size() > 0) begin
                    chk("t5_r_id", resp.r.id, exp_r[0].id);
                    chk("t5_r_last", resp.r.last, rbeat == exp_r[0].len);
                    chk("t5_r_data", resp.r.data, EXP_DATA);
                    chk("t5_r_resp", resp.r.resp, EXP_RESP);
                    if (rbeat == exp_r[0].len) begin
                        void'(exp_r.pop_front()); rbeat = 0;
                    end else rbeat++;
                end
            end
            tick;
            if (aw_hs) req.aw_valid = 1'b0;
            if (ar_hs) req.ar_valid = 1'b0;
            if (w_hs)  req.w_valid = 1'b0;
            cyc++;
            drained = aw_stim.size() == 0 && ar_stim.size() == 0 && w_stim.size() == 0 &&
                      aw_acc.size() == 0 && exp_b.size() == 0 && exp_r.size() == 0 &&
                      !req.aw_valid && !req.ar_valid && !req.w_valid;
        end
        chk("t5_drained", drained, 1);
        chk("t5_wr_cnt", wr_cnt, n_wr);
        chk("t5_rd_cnt", rd_cnt, n_rd);
        chk("t5_busy", busy, 0);

        // 6: reset in the middle of an R burst
        req = '0; req.r_ready = 1'b1;
        send_ar(9, 7);
        repeat (3) @(negedge clk);
        chk("t6_mid_burst", resp.r_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_r_valid", resp.r_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rd_cnt", rd_cnt, 0);
        chk("t6_rst_wr_cnt", wr_cnt, 0);
        @(negedge clk);
        chk("t6_next_r_valid", resp.r_valid, 0);
        rst = 1'b0;
        tick;
        send_ar(9, 3);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk("t6_r_valid", resp.r_valid, 1);
            chk("t6_r_last", resp.r.last, (b == 3));
        end
        @(negedge clk);
        chk("t6_rd_cnt", rd_cnt, 1);

        // 7: maximum burst length
        tick;
        send_ar(2, 255);
        nb = 0; got_last = 0;
        for (int g = 0; g < 300 && !got_last; g++) begin
            @(negedge clk);
            if (resp.r_valid) begin
                nb++;
                if (resp.r.last) got_last = 1;
            end
        end
        chk("t7_got_last", got_last, 1);
        chk("t7_beats", nb, 256);
        @(negedge clk);
        chk("t7_r_done", resp.r_valid, 0);
        chk("t7_rd_cnt", rd_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
